// File: rtl/fetch_branch_predictor.sv
// Fetch-side 2-bit BHT predictor with an in-order queue of in-flight predictions; PRED_STATS_EN adds retire stats.
// Latency: prediction is combinational at fetch; BHT training and queue updates land on the next clk edge.
// Backpressure: fetch_stall while DEPTH predictions are pending; a same-cycle writeback retire frees the slot.
module fetch_branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_valid,
  input  logic [15:0]                  fetch_pc,
  input  logic [15:0]                  fetch_ir,
  output logic                         fetch_stall,
  output logic                         predict_taken,
  output logic [15:0]                  predict_target,
  input  logic                         wb_valid,
  input  logic                         wb_is_branch,
  input  logic                         wb_taken,
  input  logic                         wb_squash,
  output logic                         branch_predict_status,
  output logic [$clog2(DEPTH+1)-1:0]   pending_count
`ifdef PRED_STATS_EN
  ,
  output logic [15:0]                  stat_branches,
  output logic [15:0]                  stat_mispredicts
`endif
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PW   = $clog2(DEPTH);
  localparam int NENT = 1 << IDX_BITS;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [1:0]          bht   [NENT];
  logic [IDX_BITS-1:0] q_idx [DEPTH];
  logic                q_pred[DEPTH];
  logic [PW-1:0]       head, tail;

  logic                is_br, pop, push;
  logic [IDX_BITS-1:0] fetch_idx, train_idx;
  logic [1:0]          fetch_ctr, train_ctr, train_nxt;
  logic [15:0]         seq_pc, br_off;

  assign is_br          = fetch_valid && (fetch_ir[15:12] == 4'b0000) && (fetch_ir != 16'h0000);
  assign fetch_idx      = fetch_pc[IDX_BITS:1];
  assign fetch_ctr      = bht[fetch_idx];
  assign predict_taken  = is_br && fetch_ctr[1];
  assign seq_pc         = fetch_pc + 16'd2;
  assign br_off         = {{6{fetch_ir[8]}}, fetch_ir[8:0], 1'b0};
  assign predict_target = predict_taken ? (seq_pc + br_off) : seq_pc;

  assign fetch_stall = (pending_count == FULL);
  assign pop         = wb_valid && wb_is_branch && (pending_count != '0);
  // A retiring branch frees its slot in the same cycle, so a full queue can still accept.
  assign push        = is_br && (!fetch_stall || pop) && !wb_squash;

  assign branch_predict_status = (pending_count != '0) && q_pred[head];

  assign train_idx = q_idx[head];
  assign train_ctr = bht[train_idx];

  always_comb begin
    train_nxt = train_ctr;
    if (wb_taken && (train_ctr != 2'b11))
      train_nxt = train_ctr + 2'b01;
    else if (!wb_taken && (train_ctr != 2'b00))
      train_nxt = train_ctr - 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) bht[i] <= 2'b01;
      head          <= '0;
      tail          <= '0;
      pending_count <= '0;
    end else begin
      if (pop) begin
        bht[train_idx] <= train_nxt;
        head           <= head + PW'(1);
      end
      if (push) tail <= tail + PW'(1);
      // Squash throws away every younger entry; restart both pointers from slot 0.
      if (wb_squash) begin
        head          <= '0;
        tail          <= '0;
        pending_count <= '0;
      end else if (push && !pop) begin
        pending_count <= pending_count + CW'(1);
      end else if (pop && !push) begin
        pending_count <= pending_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_idx[tail]  <= fetch_idx;
      q_pred[tail] <= predict_taken;
    end
  end

`ifdef PRED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (pop) begin
      if (stat_branches != 16'hFFFF) stat_branches <= stat_branches + 16'd1;
      if ((q_pred[head] != wb_taken) && (stat_mispredicts != 16'hFFFF))
        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_branch_predictor.md
# fetch_branch_predictor

Fetch-side branch predictor: the producer of `branch_predict_status` and the consumer of the writeback stage's branch resolution (`branch_enable`) and `squash_instruction`. It predicts each fetched BR with a table of 2-bit saturating counters and queues in-flight predictions in fetch order. At writeback it presents the oldest prediction, retires it against the actual outcome to train the table, and flushes all wrong-path entries on a squash.

## Interface
Parameters:
- `IDX_BITS`, default 4: BHT index width; table has 2^IDX_BITS counters.
- `DEPTH`, default 4: maximum in-flight predicted branches; power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `fetch_valid`  in  1  instruction presented at fetch this cycle.
- `fetch_pc`  in  16  PC of the fetched instruction (word aligned).
- `fetch_ir`  in  16  fetched instruction word.
- `fetch_stall`  out  1  queue full; fetch must hold.
- `predict_taken`  out  1  predicted direction for the current fetch.
- `predict_target`  out  16  predicted next PC.
- `wb_valid`  in  1  an instruction is in writeback this cycle.
- `wb_is_branch`  in  1  the writeback instruction is a BR (opcode 0000, IR ≠ 0).
- `wb_taken`  in  1  resolved direction (`branch_enable`).
- `wb_squash`  in  1  writeback `squash_instruction`.
- `branch_predict_status`  out  1  prediction bit of the oldest queued entry; 0 when the queue is empty.
- `pending_count`  out  $clog2(DEPTH+1)  number of queued entries.

## Operation
- Fetch-side branch detect: `is_br = fetch_valid & fetch_ir[15:12]==0000 & fetch_ir!=0`.
- BHT index is `fetch_pc[IDX_BITS:1]`. Each counter is 2 bits:
  - 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - Predict taken when counter[1] = 1.
- `predict_taken = is_br & counter[1]`.
- `predict_target`, 16-bit wraparound arithmetic:
  - Taken: `fetch_pc + 2 + (sext(fetch_ir[8:0]) << 1)`.
  - Otherwise: `fetch_pc + 2`.
- Push: when `is_br & !fetch_stall & !wb_squash`, enqueue {index, predict_taken}.
- Pop: when `wb_valid & wb_is_branch & pending_count != 0`, dequeue the head.
  - The popped entry's counter is incremented if `wb_taken`, otherwise decremented.
  - Counters saturate at 11 and 00.
- `wb_valid & wb_is_branch` with an empty queue: no pop, no training, no other effect.
- Push and pop in the same cycle: both occur and the count is unchanged. This is allowed even when the queue is full.
- `fetch_stall = (pending_count == DEPTH)`. A push is refused when full, except when a pop occurs in the same cycle.
- Squash (`wb_squash = 1`):
  - The same-cycle pop and training still apply.
  - All remaining entries are discarded and `pending_count` becomes 0.
  - Any same-cycle push is dropped, because that instruction is on the wrong path.
- Training write and fetch read of the same index in the same cycle: the read returns the old value (no bypass).

## Timing
- `predict_taken`, `predict_target`, `fetch_stall` and `branch_predict_status` are combinational from current state and inputs. There is zero-cycle latency at fetch.
- Queue state and BHT update on the rising edge after the push, pop or squash cycle.
- Effect of `rst` at the next edge:
  - Every counter becomes 01.
  - Head and tail pointers become 0 and `pending_count` becomes 0.
  - Stats counters clear.
- Reset dominates all other inputs, including during a squash or full-queue condition.
- Outputs in reset state:
  - `fetch_stall = 0`, `branch_predict_status = 0`, `pending_count = 0`.
  - `predict_taken = 0`, unless the fetch input is a BR whose counter is taken; counters reset to 01, so it is 0 directly after reset.
- Pointers wrap modulo DEPTH. Full versus empty is distinguished by `pending_count`.

## Configuration
- `PRED_STATS_EN`: when defined, adds two outputs.
  - `stat_branches` (16): increments on every pop.
  - `stat_mispredicts` (16): increments on pops where head prediction ≠ `wb_taken`.
  - Both saturate at FFFF and clear on `rst`.
- When undefined, these ports and their counters do not exist. Prediction behaviour is identical in both configurations.

## Test plan
- Reset, then fetch BR at PC 0x3000 with IR 0x0E05 -> `predict_taken=0`, `predict_target=0x3002`, `pending_count=1` next cycle.
- Resolve that branch taken twice via fetch/WB pairs at PC 0x3000 -> counter goes 01→10→11. The third fetch gives `predict_taken=1` and `predict_target=0x300C`; `branch_predict_status=1` at its WB.
- Fill the queue with DEPTH=4 BR fetches -> `fetch_stall=1`. A simultaneous 5th fetch and a WB pop -> accepted, count stays 4.
- With count 3, assert `wb_squash` with `wb_is_branch` and a same-cycle fetch BR -> head trained, count 0 next cycle, fetched entry not queued.
- Drive four consecutive not-taken resolutions on a strong-NT index -> counter stays 00 (saturation). Also drive a WB branch with an empty queue -> no state change.
- With `PRED_STATS_EN`, retire 3 branches, 1 of them mispredicted -> `stat_branches=3`, `stat_mispredicts=1`. Then assert `rst` -> both 0.
